// File: rtl/mips_branch_predictor_if.sv
// Fetch/resolve bundle between the MIPS core and its branch predictor.
// master: core side (drives lookup/update/flush); slave: predictor side.
interface mips_branch_predictor_if #(
    parameter int XLEN     = 32,
    parameter int CNT_BITS = 32
) ();
    logic [XLEN-1:0]     lookup_pc;
    logic                pred_hit;
    logic                pred_taken;
    logic [XLEN-1:0]     pred_target;
    logic                upd_en;
    logic [XLEN-1:0]     upd_pc;
    logic                upd_taken;
    logic [XLEN-1:0]     upd_target;
    logic                upd_mispredict;
    logic                flush;
    logic [CNT_BITS-1:0] br_cnt;
    logic [CNT_BITS-1:0] miss_cnt;

    modport master (
        output lookup_pc, upd_en, upd_pc, upd_taken,
        output upd_target, upd_mispredict, flush,
        input  pred_hit, pred_taken, pred_target,
        input  br_cnt, miss_cnt
    );

    modport slave (
        input  lookup_pc, upd_en, upd_pc, upd_taken,
        input  upd_target, upd_mispredict, flush,
        output pred_hit, pred_taken, pred_target,
        output br_cnt, miss_cnt
    );
endinterface

// File: rtl/mips_branch_predictor.sv
// BTB + saturating-counter BHT: zero-latency lookup for IF, training from ID.
// Ports: clk, rst_n (async, active low), bp (slave side of the predictor bundle).
module mips_branch_predictor #(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 16,
    parameter int TAG_BITS = 8,
    parameter int CTR_BITS = 2,
    parameter int MODE     = 1,
    parameter int CNT_BITS = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mips_branch_predictor_if.slave  bp
);
    localparam int IDX = $clog2(ENTRIES);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);
    localparam logic [CNT_BITS-1:0] CNT_MAX  = {CNT_BITS{1'b1}};
    localparam bit DYN = (MODE != 0);

    logic [ENTRIES-1:0]  valid_q, valid_d;
    logic [TAG_BITS-1:0] tag_q [ENTRIES];
    logic [TAG_BITS-1:0] tag_d [ENTRIES];
    logic [XLEN-1:0]     tgt_q [ENTRIES];
    logic [XLEN-1:0]     tgt_d [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_d [ENTRIES];
    logic [CNT_BITS-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_BITS-1:0] miss_cnt_q, miss_cnt_d;

    logic [IDX-1:0]      lk_idx, up_idx;
    logic [TAG_BITS-1:0] lk_tag, up_tag;
    logic                lk_hit, up_hit;
    logic                unused_bits;

    assign lk_idx = bp.lookup_pc[IDX+1:2];
    assign lk_tag = bp.lookup_pc[IDX+1+TAG_BITS:IDX+2];
    assign up_idx = bp.upd_pc[IDX+1:2];
    assign up_tag = bp.upd_pc[IDX+1+TAG_BITS:IDX+2];

    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    // Pre-update contents only: a same-cycle update shows up next cycle.
    assign bp.pred_hit    = DYN && lk_hit;
    assign bp.pred_taken  = DYN && lk_hit && ctr_q[lk_idx][CTR_BITS-1];
    assign bp.pred_target = (DYN && lk_hit) ? tgt_q[lk_idx] : '0;
    assign bp.br_cnt      = br_cnt_q;
    assign bp.miss_cnt    = miss_cnt_q;

    // PC alignment/upper bits take no part in indexing.
    assign unused_bits = ^{bp.lookup_pc, bp.upd_pc};

    always_comb begin
        valid_d    = valid_q;
        tag_d      = tag_q;
        tgt_d      = tgt_q;
        ctr_d      = ctr_q;
        br_cnt_d   = br_cnt_q;
        miss_cnt_d = miss_cnt_q;

        if (bp.upd_en) begin
            if (br_cnt_q != CNT_MAX)
                br_cnt_d = br_cnt_q + CNT_BITS'(1);
            if (bp.upd_mispredict && (miss_cnt_q != CNT_MAX))
                miss_cnt_d = miss_cnt_q + CNT_BITS'(1);
        end

        if (DYN) begin
            if (bp.flush) begin
                valid_d = '0;
                for (int i = 0; i < ENTRIES; i++)
                    ctr_d[i] = '0;
            end else if (bp.upd_en) begin
                if (up_hit) begin
                    if (bp.upd_taken) begin
                        tgt_d[up_idx] = bp.upd_target;
                        if (ctr_q[up_idx] != CTR_MAX)
                            ctr_d[up_idx] = ctr_q[up_idx] + CTR_BITS'(1);
                    end else if (ctr_q[up_idx] != '0) begin
                        ctr_d[up_idx] = ctr_q[up_idx] - CTR_BITS'(1);
                    end
                end else if (bp.upd_taken) begin
                    // Allocation evicts whatever aliases on this index.
                    valid_d[up_idx] = 1'b1;
                    tag_d[up_idx]   = up_tag;
                    tgt_d[up_idx]   = bp.upd_target;
                    ctr_d[up_idx]   = CTR_WEAK;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= '0;
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            tag_q      <= tag_d;
            tgt_q      <= tgt_d;
            ctr_q      <= ctr_d;
            br_cnt_q   <= br_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end
endmodule

// File: tb/tb_mips_branch_predictor.sv
// Bench for mips_branch_predictor: three builds (default, small, static)
// driven by one stimulus stream and checked against a table-level model.
module tb_mips_branch_predictor;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mips_branch_predictor_if #(.XLEN(32), .CNT_BITS(32)) i0 ();
    mips_branch_predictor_if #(.XLEN(32), .CNT_BITS(4))  i1 ();
    mips_branch_predictor_if #(.XLEN(32), .CNT_BITS(32)) i2 ();

    mips_branch_predictor #(.ENTRIES(16), .CTR_BITS(2), .MODE(1), .CNT_BITS(32))
        d0 (.clk(clk), .rst_n(rst_n), .bp(i0));
    mips_branch_predictor #(.ENTRIES(4), .CTR_BITS(1), .MODE(1), .CNT_BITS(4))
        d1 (.clk(clk), .rst_n(rst_n), .bp(i1));
    mips_branch_predictor #(.ENTRIES(16), .CTR_BITS(2), .MODE(0), .CNT_BITS(32))
        d2 (.clk(clk), .rst_n(rst_n), .bp(i2));

    logic        hit_o [3];
    logic        tk_o  [3];
    logic [31:0] tgt_o [3];
    logic [31:0] br_o  [3];
    logic [31:0] miss_o[3];

    assign hit_o[0] = i0.pred_hit;    assign hit_o[1] = i1.pred_hit;
    assign hit_o[2] = i2.pred_hit;
    assign tk_o[0]  = i0.pred_taken;  assign tk_o[1]  = i1.pred_taken;
    assign tk_o[2]  = i2.pred_taken;
    assign tgt_o[0] = i0.pred_target; assign tgt_o[1] = i1.pred_target;
    assign tgt_o[2] = i2.pred_target;
    assign br_o[0]  = i0.br_cnt;      assign br_o[1]  = {28'b0, i1.br_cnt};
    assign br_o[2]  = i2.br_cnt;
    assign miss_o[0] = i0.miss_cnt;   assign miss_o[1] = {28'b0, i1.miss_cnt};
    assign miss_o[2] = i2.miss_cnt;

    // Build configurations of the three instances.
    int ENT [3] = '{16, 4, 16};
    int CB  [3] = '{2, 1, 2};
    int NB  [3] = '{32, 4, 32};
    int MD  [3] = '{1, 1, 0};

    // Reference model: per build, a table of entries addressed arithmetically.
    bit          m_valid[3][16];
    int          m_tag  [3][16];
    logic [31:0] m_tgt  [3][16];
    int          m_ctr  [3][16];
    longint      m_br   [3];
    longint      m_miss [3];

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    function automatic int m_idx(int k, logic [31:0] pc);
        longint p = longint'(pc);
        return int'((p / 4) % ENT[k]);
    endfunction

    function automatic int m_tg(int k, logic [31:0] pc);
        longint p = longint'(pc);
        return int'((p / (4 * ENT[k])) % 256);
    endfunction

    function automatic bit e_hit(int k, logic [31:0] pc);
        int i = m_idx(k, pc);
        return MD[k] != 0 && m_valid[k][i] && m_tag[k][i] == m_tg(k, pc);
    endfunction

    function automatic bit e_taken(int k, logic [31:0] pc);
        return e_hit(k, pc) && m_ctr[k][m_idx(k, pc)] >= (1 << (CB[k] - 1));
    endfunction

    function automatic logic [31:0] e_tgt(int k, logic [31:0] pc);
        return e_hit(k, pc) ? m_tgt[k][m_idx(k, pc)] : 32'h0;
    endfunction

    function automatic void m_reset();
        for (int k = 0; k < 3; k++) begin
            m_br[k] = 0;
            m_miss[k] = 0;
            for (int i = 0; i < 16; i++) begin
                m_valid[k][i] = 0;
                m_tag[k][i] = 0;
                m_tgt[k][i] = 0;
                m_ctr[k][i] = 0;
            end
        end
    endfunction

    function automatic void m_edge(bit en, logic [31:0] pc, bit tk,
                                   logic [31:0] tgt, bit mp, bit fl);
        for (int k = 0; k < 3; k++) begin
            longint cmax = (64'd1 << NB[k]) - 1;
            int i = m_idx(k, pc);
            bit h = e_hit(k, pc);
            if (en) begin
                if (m_br[k] < cmax) m_br[k]++;
                if (mp && m_miss[k] < cmax) m_miss[k]++;
            end
            if (MD[k] == 0) continue;
            if (fl) begin
                for (int j = 0; j < 16; j++) begin
                    m_valid[k][j] = 0;
                    m_ctr[k][j] = 0;
                end
            end else if (en) begin
                if (h && tk) begin
                    m_tgt[k][i] = tgt;
                    if (m_ctr[k][i] < (1 << CB[k]) - 1) m_ctr[k][i]++;
                end else if (h) begin
                    if (m_ctr[k][i] > 0) m_ctr[k][i]--;
                end else if (tk) begin
                    m_valid[k][i] = 1;
                    m_tag[k][i] = m_tg(k, pc);
                    m_tgt[k][i] = tgt;
                    m_ctr[k][i] = 1 << (CB[k] - 1);
                end
            end
        end
    endfunction

    task automatic drive(logic [31:0] lk, bit en, logic [31:0] pc, bit tk,
                         logic [31:0] tgt, bit mp, bit fl);
        i0.lookup_pc = lk;  i1.lookup_pc = lk;  i2.lookup_pc = lk;
        i0.upd_en = en;     i1.upd_en = en;     i2.upd_en = en;
        i0.upd_pc = pc;     i1.upd_pc = pc;     i2.upd_pc = pc;
        i0.upd_taken = tk;  i1.upd_taken = tk;  i2.upd_taken = tk;
        i0.upd_target = tgt; i1.upd_target = tgt; i2.upd_target = tgt;
        i0.upd_mispredict = mp; i1.upd_mispredict = mp;
        i2.upd_mispredict = mp;
        i0.flush = fl;      i1.flush = fl;      i2.flush = fl;
    endtask

    task automatic compare_all(logic [31:0] lk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("hit[%0d]", k), 64'(hit_o[k]), 64'(e_hit(k, lk)));
            chk($sformatf("taken[%0d]", k), 64'(tk_o[k]), 64'(e_taken(k, lk)));
            chk($sformatf("target[%0d]", k), 64'(tgt_o[k]), 64'(e_tgt(k, lk)));
            chk($sformatf("br_cnt[%0d]", k), 64'(br_o[k]), 64'(m_br[k]));
            chk($sformatf("miss_cnt[%0d]", k), 64'(miss_o[k]), 64'(m_miss[k]));
        end
    endtask

    // Called just after a falling edge; ends on the next falling edge.
    task automatic step(logic [31:0] lk, bit en, logic [31:0] pc, bit tk,
                        logic [31:0] tgt, bit mp, bit fl);
        drive(lk, en, pc, tk, tgt, mp, fl);
        #1;
        compare_all(lk);
        @(posedge clk);
        m_edge(en, pc, tk, tgt, mp, fl);
        @(negedge clk);
    endtask

    task automatic look(logic [31:0] lk);
        step(lk, 0, 32'h0, 0, 32'h0, 0, 0);
    endtask

    task automatic upd(logic [31:0] pc, bit tk, logic [31:0] tgt, bit mp);
        step(pc, 1, pc, tk, tgt, mp, 0);
    endtask

    // Async reset mid-cycle: outputs must clear before any clock edge.
    task automatic reset_pulse();
        #2;
        rst_n = 1'b0;
        drive(32'h40, 0, 32'h0, 0, 32'h0, 0, 0);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_hit[%0d]", k), 64'(hit_o[k]), 64'd0);
            chk($sformatf("rst_taken[%0d]", k), 64'(tk_o[k]), 64'd0);
            chk($sformatf("rst_target[%0d]", k), 64'(tgt_o[k]), 64'd0);
            chk($sformatf("rst_br[%0d]", k), 64'(br_o[k]), 64'd0);
            chk($sformatf("rst_miss[%0d]", k), 64'(miss_o[k]), 64'd0);
        end
        m_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rpc();
        return (32'($urandom_range(0, 1)) << 12) | ($urandom & 32'h3F);
    endfunction

    initial begin
        m_reset();
        reset_pulse();

        // Allocation on a taken miss; not-taken miss allocates nothing.
        upd(32'h40, 1, 32'h80, 1);
        look(32'h40);
        chk("alloc_hit", 64'(hit_o[0]), 64'd1);
        chk("alloc_taken", 64'(tk_o[0]), 64'd1);
        chk("alloc_target", 64'(tgt_o[0]), 64'h80);
        chk("alloc_br", 64'(br_o[0]), 64'd1);
        chk("alloc_miss", 64'(miss_o[0]), 64'd1);
        chk("static_hit", 64'(hit_o[2]), 64'd0);
        upd(32'h44, 0, 32'h99, 0);
        look(32'h44);
        chk("nt_noalloc", 64'(hit_o[0]), 64'd0);

        // Counter saturation on 0x40.
        upd(32'h40, 0, 32'h0, 0);
        look(32'h40);
        chk("sat_dn_hit", 64'(hit_o[0]), 64'd1);
        chk("sat_dn_taken", 64'(tk_o[0]), 64'd0);
        chk("ctr1_nt_taken", 64'(tk_o[1]), 64'd0);
        repeat (4) upd(32'h40, 1, 32'h80, 0);
        upd(32'h40, 0, 32'h0, 1);
        look(32'h40);
        chk("sat_up_taken", 64'(tk_o[0]), 64'd1);

        // Aliasing entry at 0x440 evicts 0x40.
        look(32'h440);
        chk("alias_miss", 64'(hit_o[0]), 64'd0);
        upd(32'h440, 1, 32'h10, 1);
        look(32'h440);
        chk("alias_hit", 64'(hit_o[0]), 64'd1);
        chk("alias_target", 64'(tgt_o[0]), 64'h10);
        look(32'h40);
        chk("alias_evict", 64'(hit_o[0]), 64'd0);

        // Same-cycle lookup/update: no write-through.
        upd(32'h80, 1, 32'h200, 0);
        look(32'h80);
        chk("wt_next_hit", 64'(hit_o[0]), 64'd1);

        // Flush beats a concurrent update.
        upd(32'h40, 1, 32'h80, 0);
        step(32'h40, 1, 32'h40, 1, 32'h84, 0, 1);
        look(32'h40);
        chk("flush_hit", 64'(hit_o[0]), 64'd0);
        chk("flush_br_kept", 64'(br_o[0]), 64'(m_br[0]));

        // Small build counters saturate at 15.
        repeat (17) upd(32'h100, 1, 32'h300, 1);
        look(32'h100);
        chk("sat_br4", 64'(br_o[1]), 64'd15);
        chk("sat_miss4", 64'(miss_o[1]), 64'd15);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] pc = rpc();
            logic [31:0] lk = ($urandom_range(0, 2) == 0) ? pc : rpc();
            step(lk, $urandom_range(0, 9) < 7, pc, 1'($urandom_range(0, 1)),
                 $urandom, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 39) == 0);
        end

        // Reset mid-operation, then train right away.
        reset_pulse();
        upd(32'h40, 1, 32'h80, 0);
        look(32'h40);
        chk("post_rst_hit", 64'(hit_o[0]), 64'd1);
        chk("post_rst_br", 64'(br_o[0]), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
